// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/step control slice:
// forwarding-select encodings, step FSM states and a forwarding
// priority helper.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG   = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_WB    = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } step_state_t;

  // The younger producer (EX/MEM) wins over the older one (MEM/WB).
  function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)
      return FWD_EXMEM;
    else if (memwb_hit)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the core top (master) and hazard_ctrl (slave):
// pipeline status in, per-stage controls and forwarding selects out.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4
) ();

  // run control
  logic              pause;
  logic              step_pulse;

  // ID stage
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_branch_taken;

  // ID/EX, EX/MEM, MEM/WB
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] idex_wa;
  logic              idex_regwrite;
  logic              idex_memread;
  logic [REG_AW-1:0] exmem_wa;
  logic              exmem_regwrite;
  logic [REG_AW-1:0] memwb_wa;
  logic              memwb_regwrite;

  // controls
  logic              adv;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_bubble;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic              id_byp_a;
  logic              id_byp_b;
  logic              busy_stall;
  logic [15:0]       perf_stall_cnt;
  logic [15:0]       perf_flush_cnt;

  modport slave (
    input  pause, step_pulse,
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
    input  ex_rs, ex_rt, idex_wa, idex_regwrite, idex_memread,
    input  exmem_wa, exmem_regwrite, memwb_wa, memwb_regwrite,
    output adv, pc_en, ifid_en, ifid_flush, idex_bubble,
    output fwd_a, fwd_b, id_byp_a, id_byp_b, busy_stall,
    output perf_stall_cnt, perf_flush_cnt
  );

  modport master (
    output pause, step_pulse,
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch_taken,
    output ex_rs, ex_rt, idex_wa, idex_regwrite, idex_memread,
    output exmem_wa, exmem_regwrite, memwb_wa, memwb_regwrite,
    input  adv, pc_en, ifid_en, ifid_flush, idex_bubble,
    input  fwd_a, fwd_b, id_byp_a, id_byp_b, busy_stall,
    input  perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_step_gate.sv
// Run/halt/single-step engine. Produces go, the "pipeline advances
// this cycle" strobe. Step requests arriving while a step is already
// executing (or while a queued step is being launched) are queued in a
// saturating counter and replayed one per HALT->STEP round trip.
module step_gate
  import hazard_pkg::*;
#(
  parameter int STEP_QW = 4
) (
  input  logic PCLK,
  input  logic RST,
  input  logic pause,
  input  logic step_pulse,
  output logic go
);

  localparam logic [STEP_QW-1:0] PEND_MAX = {STEP_QW{1'b1}};
  localparam logic [STEP_QW-1:0] PEND_ONE = STEP_QW'(1);

  step_state_t        state_reg, state_next;
  logic [STEP_QW-1:0] pend_reg, pend_next;

  // state and pending-step registers
  always_ff @(posedge PCLK) begin
    if (RST) begin
      state_reg <= ST_RUN;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
    end
  end

  // next state and queue bookkeeping; a pulse that launches a step is
  // consumed by it, otherwise the launch drains one queued request
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    case (state_reg)
      ST_RUN: begin
        if (pause)
          state_next = ST_HALT;
      end
      ST_HALT: begin
        if (!pause) begin
          state_next = ST_RUN;
        end else if (step_pulse || (pend_reg != '0)) begin
          state_next = ST_STEP;
          if (!step_pulse)
            pend_next = pend_reg - PEND_ONE;
        end
      end
      ST_STEP: begin
        state_next = pause ? ST_HALT : ST_RUN;
        if (step_pulse && (pend_reg != PEND_MAX))
          pend_next = pend_reg + PEND_ONE;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign go = ~RST & (((state_reg == ST_RUN) & ~pause) | (state_reg == ST_STEP));

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline control: per-stage advance enables, load-use stall,
// branch flush, EX forwarding selects and ID writeback bypass.
// Optional feature macro: HAZARD_PERF_EN builds the stall/flush
// performance counters; without it both counter outputs read zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int LU_BUBBLES   = 1,
  parameter int R0_HARDWIRED = 1,
  parameter int STEP_QW      = 4
) (
  input  logic         PCLK,
  input  logic         RST,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

  // Register 0 is never a real producer when it is hardwired.
  function automatic logic addr_ok(input logic [REG_AW-1:0] a);
    return (R0_HARDWIRED == 0) || (a != '0);
  endfunction

  logic go;

  step_gate #(
    .STEP_QW (STEP_QW)
  ) u_step_gate (
    .PCLK       (PCLK),
    .RST        (RST),
    .pause      (bus.pause),
    .step_pulse (bus.step_pulse),
    .go         (go)
  );

  // operand-indexed views so both read ports share one generate body
  logic [REG_AW-1:0] ex_src  [2];
  logic [REG_AW-1:0] id_src  [2];
  logic              id_uses [2];
  fwd_sel_t          fwd_sel [2];
  logic              byp     [2];
  logic              lu_hit  [2];

  assign ex_src[0]  = bus.ex_rs;
  assign ex_src[1]  = bus.ex_rt;
  assign id_src[0]  = bus.id_rs;
  assign id_src[1]  = bus.id_rt;
  assign id_uses[0] = bus.id_uses_rs;
  assign id_uses[1] = bus.id_uses_rt;

  logic exmem_live, memwb_live, idex_load_live;

  assign exmem_live     = bus.exmem_regwrite & addr_ok(bus.exmem_wa);
  assign memwb_live     = bus.memwb_regwrite & addr_ok(bus.memwb_wa);
  assign idex_load_live = bus.idex_memread & bus.idex_regwrite & addr_ok(bus.idex_wa);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign fwd_sel[gi] = RST ? FWD_REG
                               : fwd_pick(exmem_live & (bus.exmem_wa == ex_src[gi]),
                                          memwb_live & (bus.memwb_wa == ex_src[gi]));
      assign byp[gi]     = ~RST & memwb_live & (bus.memwb_wa == id_src[gi]);
      assign lu_hit[gi]  = id_uses[gi] & (bus.idex_wa == id_src[gi]);
    end
  endgenerate

  assign bus.fwd_a    = fwd_sel[0];
  assign bus.fwd_b    = fwd_sel[1];
  assign bus.id_byp_a = byp[0];
  assign bus.id_byp_b = byp[1];

  // load-use stall: the detection cycle plus LU_BUBBLES-1 counted cycles
  logic       lu_hazard, stall;
  logic [1:0] lu_cnt_reg, lu_cnt_next;

  assign lu_hazard = idex_load_live & (lu_hit[0] | lu_hit[1]);
  assign stall     = go & (lu_hazard | (lu_cnt_reg != 2'd0));

  // bubble countdown only moves on cycles where the pipeline advances
  always_comb begin
    lu_cnt_next = lu_cnt_reg;
    if (go) begin
      if (lu_cnt_reg != 2'd0)
        lu_cnt_next = lu_cnt_reg - 2'd1;
      else if (lu_hazard)
        lu_cnt_next = LU_LOAD;
    end
  end

  // bubble counter register
  always_ff @(posedge PCLK) begin
    if (RST)
      lu_cnt_reg <= 2'd0;
    else
      lu_cnt_reg <= lu_cnt_next;
  end

  logic flush;
  assign flush = go & bus.id_branch_taken & ~stall;

  assign bus.adv         = go;
  assign bus.pc_en       = go & ~stall;
  assign bus.ifid_en     = go & ~stall;
  assign bus.ifid_flush  = flush;
  assign bus.idex_bubble = stall;
  assign bus.busy_stall  = stall;

`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt_reg, perf_flush_cnt_reg;

  // wrapping event counters for stall and flush cycles
  always_ff @(posedge PCLK) begin
    if (RST) begin
      perf_stall_cnt_reg <= 16'd0;
      perf_flush_cnt_reg <= 16'd0;
    end else begin
      if (stall)
        perf_stall_cnt_reg <= perf_stall_cnt_reg + 16'd1;
      if (flush)
        perf_flush_cnt_reg <= perf_flush_cnt_reg + 16'd1;
    end
  end

  assign bus.perf_stall_cnt = RST ? 16'd0 : perf_stall_cnt_reg;
  assign bus.perf_flush_cnt = RST ? 16'd0 : perf_flush_cnt_reg;
`else
  assign bus.perf_stall_cnt = 16'd0;
  assign bus.perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: forwarding table, directed
// stall/flush/step/reset sequences, then a randomized run against a
// cycle-level reference model of the control rules.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int AW  = 4;
  localparam int LUB = 2;
  localparam int QW  = 4;
  localparam int QMAX = (1 << QW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_AW(AW)) bus ();

  hazard_ctrl #(
    .REG_AW       (AW),
    .LU_BUBBLES   (LUB),
    .R0_HARDWIRED (1),
    .STEP_QW      (QW)
  ) dut (
    .PCLK (clk),
    .RST  (rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.step_pulse      = 1'b0;
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.ex_rs           = '0;
    bus.ex_rt           = '0;
    bus.idex_wa         = '0;
    bus.idex_regwrite   = 1'b0;
    bus.idex_memread    = 1'b0;
    bus.exmem_wa        = '0;
    bus.exmem_regwrite  = 1'b0;
    bus.memwb_wa        = '0;
    bus.memwb_regwrite  = 1'b0;
  endtask

  // load to r5 sitting in ID/EX, consumed by ID through rs
  task automatic set_load_use();
    bus.idex_memread  = 1'b1;
    bus.idex_regwrite = 1'b1;
    bus.idex_wa       = 4'd5;
    bus.id_rs         = 4'd5;
    bus.id_uses_rs    = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_adv"},   32'(bus.adv), 32'd0);
    chk({tag, "_pc_en"}, 32'(bus.pc_en), 32'd0);
    chk({tag, "_ifid"},  32'(bus.ifid_en), 32'd0);
    chk({tag, "_flush"}, 32'(bus.ifid_flush), 32'd0);
    chk({tag, "_bub"},   32'(bus.idex_bubble), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy_stall), 32'd0);
    chk({tag, "_fwd"},   32'({bus.fwd_a, bus.fwd_b}), 32'd0);
    chk({tag, "_byp"},   32'({bus.id_byp_a, bus.id_byp_b}), 32'd0);
    chk({tag, "_perf"},  32'({bus.perf_stall_cnt, bus.perf_flush_cnt}), 32'd0);
  endtask

  function automatic logic [15:0] perf_exp(input int n);
`ifdef HAZARD_PERF_EN
    return 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  typedef struct {
    logic           exmem_rw;
    logic [AW-1:0]  exmem_wa;
    logic           memwb_rw;
    logic [AW-1:0]  memwb_wa;
    logic [AW-1:0]  ex_rs, ex_rt, id_rs, id_rt;
    fwd_sel_t       e_fa, e_fb;
    logic           e_ba, e_bb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    bus.pause = 1'b0;
    clear_inputs();
    rst = 1'b1;

    tbl[0] = '{1'b1, 4'd3, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, FWD_EXMEM, FWD_EXMEM, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 4'd3, 1'b1, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, FWD_WB,    FWD_WB,    1'b1, 1'b1};
    tbl[2] = '{1'b1, 4'd0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, FWD_REG,   FWD_REG,   1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'd7, 1'b1, 4'd7, 4'd7, 4'd2, 4'd2, 4'd7, FWD_EXMEM, FWD_REG,   1'b0, 1'b1};
    tbl[4] = '{1'b1, 4'd7, 1'b1, 4'd0, 4'd7, 4'd7, 4'd0, 4'd0, FWD_EXMEM, FWD_EXMEM, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 4'd4, 1'b0, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, FWD_REG,   FWD_REG,   1'b0, 1'b0};
    tbl[6] = '{1'b1, 4'd5, 1'b1, 4'd6, 4'd6, 4'd5, 4'd6, 4'd5, FWD_WB,    FWD_EXMEM, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'd9, 1'b1, 4'd15, 4'd15, 4'd9, 4'd15, 4'd15, FWD_WB,  FWD_REG,   1'b1, 1'b1};

    // ---------------- reset state, with matches present on the inputs
    repeat (2) @(negedge clk);
    bus.exmem_regwrite  = 1'b1; bus.exmem_wa = 4'd3; bus.ex_rs = 4'd3;
    bus.memwb_regwrite  = 1'b1; bus.memwb_wa = 4'd3; bus.id_rs = 4'd3;
    bus.id_branch_taken = 1'b1;
    #2;
    chk_all_zero("reset");
    $display("reset state checked");

    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #2;
    chk("post_reset_adv", 32'(bus.adv), 32'd1);
    chk("post_reset_pc_en", 32'(bus.pc_en), 32'd1);

    // ---------------- forwarding / bypass table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.exmem_regwrite = tbl[i].exmem_rw;
      bus.exmem_wa       = tbl[i].exmem_wa;
      bus.memwb_regwrite = tbl[i].memwb_rw;
      bus.memwb_wa       = tbl[i].memwb_wa;
      bus.ex_rs          = tbl[i].ex_rs;
      bus.ex_rt          = tbl[i].ex_rt;
      bus.id_rs          = tbl[i].id_rs;
      bus.id_rt          = tbl[i].id_rt;
      #2;
      chk("tbl_fwd_a", 32'(bus.fwd_a), 32'(tbl[i].e_fa));
      chk("tbl_fwd_b", 32'(bus.fwd_b), 32'(tbl[i].e_fb));
      chk("tbl_byp_a", 32'(bus.id_byp_a), 32'(tbl[i].e_ba));
      chk("tbl_byp_b", 32'(bus.id_byp_b), 32'(tbl[i].e_bb));
      $display("vec %0d: fwd_a=%b fwd_b=%b byp_a=%b byp_b=%b", i, bus.fwd_a, bus.fwd_b,
               bus.id_byp_a, bus.id_byp_b);
    end

    // ---------------- load-use, two bubbles
    @(negedge clk);
    clear_inputs();
    set_load_use();
    #2;
    chk("lu1_adv", 32'(bus.adv), 32'd1);
    chk("lu1_pc_en", 32'(bus.pc_en), 32'd0);
    chk("lu1_ifid_en", 32'(bus.ifid_en), 32'd0);
    chk("lu1_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("lu1_busy", 32'(bus.busy_stall), 32'd1);
    @(negedge clk);
    bus.idex_memread  = 1'b0;   // ID/EX now holds the bubble
    bus.idex_regwrite = 1'b0;
    #2;
    chk("lu2_pc_en", 32'(bus.pc_en), 32'd0);
    chk("lu2_bubble", 32'(bus.idex_bubble), 32'd1);
    @(negedge clk);
    #2;
    chk("lu3_pc_en", 32'(bus.pc_en), 32'd1);
    chk("lu3_bubble", 32'(bus.idex_bubble), 32'd0);
    chk("lu3_perf_stall", 32'(bus.perf_stall_cnt), 32'(perf_exp(2)));
    $display("load-use sequence: 2 bubbles checked");

    // load that ID does not read, and a load to r0: no stall
    @(negedge clk);
    set_load_use();
    bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b1; bus.id_rt = 4'd6;
    #2;
    chk("lu_unused_src", 32'(bus.pc_en), 32'd1);
    @(negedge clk);
    set_load_use();
    bus.idex_wa = 4'd0; bus.id_rs = 4'd0;
    #2;
    chk("lu_r0", 32'(bus.pc_en), 32'd1);

    // ---------------- branch flush
    @(negedge clk);
    clear_inputs();
    bus.id_branch_taken = 1'b1;
    #2;
    chk("br_flush", 32'(bus.ifid_flush), 32'd1);
    @(negedge clk);
    bus.id_branch_taken = 1'b0;
    #2;
    chk("br_flush_off", 32'(bus.ifid_flush), 32'd0);
    @(negedge clk);
    set_load_use();
    bus.id_branch_taken = 1'b1;
    #2;
    chk("br_in_stall1", 32'(bus.ifid_flush), 32'd0);
    @(negedge clk);
    bus.idex_memread = 1'b0; bus.idex_regwrite = 1'b0;
    #2;
    chk("br_in_stall2", 32'(bus.ifid_flush), 32'd0);
    @(negedge clk);
    #2;
    chk("br_after_stall", 32'(bus.ifid_flush), 32'd1);
    chk("br_perf_flush", 32'(bus.perf_flush_cnt), 32'(perf_exp(1)));
    @(negedge clk);
    clear_inputs();
    #2;
    chk("br_perf_flush2", 32'(bus.perf_flush_cnt), 32'(perf_exp(2)));
    chk("br_perf_stall", 32'(bus.perf_stall_cnt), 32'(perf_exp(4)));
    $display("branch flush sequence checked");

    // ---------------- single step: three back-to-back pulses
    @(negedge clk);
    bus.pause = 1'b1;
    #2;
    chk("pause_same_cycle", 32'(bus.adv), 32'd0);
    @(negedge clk);
    #2;
    chk("halt_idle", 32'(bus.adv), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.step_pulse = (i < 3);
      #2;
      chk("step_adv", 32'(bus.adv), 32'((i == 1) || (i == 3) || (i == 5)));
      chk("step_pc_en", 32'(bus.pc_en), 32'((i == 1) || (i == 3) || (i == 5)));
      $display("step cycle %0d: pulse=%b adv=%b", i, bus.step_pulse, bus.adv);
    end
    @(negedge clk);
    bus.pause = 1'b0;
    #2;
    chk("unpause_n", 32'(bus.adv), 32'd0);
    @(negedge clk);
    #2;
    chk("unpause_n1", 32'(bus.adv), 32'd1);

    // ---------------- reset during a stall
    @(negedge clk);
    set_load_use();
    #2;
    chk("rst_stall_pre", 32'(bus.busy_stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    #2;
    chk_all_zero("rst_stall");
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_stall_adv", 32'(bus.adv), 32'd1);
    chk("rst_stall_pc_en", 32'(bus.pc_en), 32'd1);
    chk("rst_stall_busy", 32'(bus.busy_stall), 32'd0);

    // ---------------- reset with four queued steps
    @(negedge clk);
    bus.pause = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.step_pulse = 1'b1;
    end
    @(negedge clk);
    bus.step_pulse = 1'b0;
    rst = 1'b1;
    #2;
    chk_all_zero("rst_pend");
    @(negedge clk);
    rst = 1'b0;
    bus.pause = 1'b0;
    #2;
    chk("rst_pend_adv", 32'(bus.adv), 32'd1);
    @(negedge clk);
    bus.pause = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk("rst_pend_no_step", 32'(bus.adv), 32'd0);
      @(negedge clk);
    end
    bus.pause = 1'b0;
    $display("reset sequences checked");

    // ---------------- randomized run against the reference model
    rst = 1'b1;
    @(negedge clk);
    begin
      bit         m_prev_pause = 1'b0;  // pause as sampled last cycle
      bit         m_step       = 1'b0;  // a single step executes this cycle
      int         m_req        = 0;     // step requests waiting
      int         m_left       = 0;     // counted bubbles still owed
      logic [15:0] m_ps = 16'd0, m_pf = 16'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bit r, go, haz, stl, fl, stn;
        logic [1:0] efa, efb;
        logic eba, ebb;
        @(negedge clk);
        r = ($urandom_range(0, 399) == 0);
        rst = r;
        if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
        bus.step_pulse      = ($urandom_range(0, 9) < 6);
        bus.id_rs           = 4'($urandom_range(0, 3));
        bus.id_rt           = 4'($urandom_range(0, 3));
        bus.id_uses_rs      = 1'($urandom_range(0, 1));
        bus.id_uses_rt      = 1'($urandom_range(0, 1));
        bus.id_branch_taken = ($urandom_range(0, 3) == 0);
        bus.ex_rs           = 4'($urandom_range(0, 3));
        bus.ex_rt           = 4'($urandom_range(0, 3));
        bus.idex_wa         = 4'($urandom_range(0, 3));
        bus.idex_regwrite   = 1'($urandom_range(0, 1));
        bus.idex_memread    = ($urandom_range(0, 2) == 0);
        bus.exmem_wa        = 4'($urandom_range(0, 3));
        bus.exmem_regwrite  = 1'($urandom_range(0, 1));
        bus.memwb_wa        = 4'($urandom_range(0, 3));
        bus.memwb_regwrite  = 1'($urandom_range(0, 1));
        #2;
        go  = !r && (m_step || (!m_prev_pause && !bus.pause));
        haz = bus.idex_memread && bus.idex_regwrite && (bus.idex_wa != 0) &&
              ((bus.id_uses_rs && bus.idex_wa == bus.id_rs) ||
               (bus.id_uses_rt && bus.idex_wa == bus.id_rt));
        stl = go && (haz || m_left > 0);
        fl  = go && bus.id_branch_taken && !stl;
        efa = FWD_REG; efb = FWD_REG; eba = 1'b0; ebb = 1'b0;
        if (!r) begin
          if (bus.exmem_regwrite && bus.exmem_wa != 0 && bus.exmem_wa == bus.ex_rs) efa = FWD_EXMEM;
          else if (bus.memwb_regwrite && bus.memwb_wa != 0 && bus.memwb_wa == bus.ex_rs) efa = FWD_WB;
          if (bus.exmem_regwrite && bus.exmem_wa != 0 && bus.exmem_wa == bus.ex_rt) efb = FWD_EXMEM;
          else if (bus.memwb_regwrite && bus.memwb_wa != 0 && bus.memwb_wa == bus.ex_rt) efb = FWD_WB;
          eba = bus.memwb_regwrite && bus.memwb_wa != 0 && bus.memwb_wa == bus.id_rs;
          ebb = bus.memwb_regwrite && bus.memwb_wa != 0 && bus.memwb_wa == bus.id_rt;
        end
        chk("rand_ctl",
            32'({bus.adv, bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.busy_stall,
                 bus.fwd_a, bus.fwd_b, bus.id_byp_a, bus.id_byp_b}),
            32'({go, go && !stl, go && !stl, fl, stl, stl, efa, efb, eba, ebb}));
`ifdef HAZARD_PERF_EN
        chk("rand_perf", 32'({bus.perf_stall_cnt, bus.perf_flush_cnt}), r ? 32'd0 : {m_ps, m_pf});
`else
        chk("rand_perf", 32'({bus.perf_stall_cnt, bus.perf_flush_cnt}), 32'd0);
`endif
        // advance the model to the next cycle
        if (r) begin
          m_prev_pause = 1'b0; m_step = 1'b0; m_req = 0; m_left = 0;
          m_ps = 16'd0; m_pf = 16'd0;
        end else begin
          stn = !m_step && m_prev_pause && bus.pause && (bus.step_pulse || m_req > 0);
          if (m_step && bus.step_pulse && m_req < QMAX) m_req++;
          if (stn && !bus.step_pulse) m_req--;
          m_step       = stn;
          m_prev_pause = bus.pause;
          if (go) begin
            if (m_left > 0) m_left--;
            else if (haz) m_left = LUB - 1;
          end
          if (stl) m_ps++;
          if (fl)  m_pf++;
        end
      end
    end
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
